prog_sequence_detector: RTL
===========================

# prog_sequence_detector

Parametrised serial-bit pattern detector. It succeeds the fixed 5-bit overlapping detector and adds:
- a runtime-loadable pattern of up to MAX_LEN bits;
- selectable overlapping or non-overlapping detection;
- an input-valid qualifier;
- a saturating match counter.

It sits on a serial bit stream and flags each completed occurrence of the programmed pattern with a one-cycle registered pulse.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (≥2)
- COUNT_W, 16: width of match counter
- LEN_W, $clog2(MAX_LEN+1): derived width of length fields

- clk  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-high; clears all state
- x_valid  input  1  x is sampled only when high
- x  input  1  serial data bit
- cfg_load  input  1  one-cycle strobe; loads cfg_* fields
- cfg_pattern  input  MAX_LEN  pattern; bit [cfg_len-1] is first bit expected, bit [0] last
- cfg_len  input  LEN_W  pattern length, legal range 1..MAX_LEN
- cfg_overlap  input  1  1 = overlapping, 0 = non-overlapping
- y  output  1  registered match pulse, one cycle per match
- match_count  output  COUNT_W  saturating count of matches since reset or last cfg_load
- cfg_err  output  1  one-cycle pulse when a load is rejected
- active  output  1  high in RUN state

## Operation
- States: IDLE (no detection) and RUN. Reset → IDLE.
- **cfg_load with 1 ≤ cfg_len ≤ MAX_LEN:**
  - latch pattern, len and overlap;
  - clear history, fill counter and match_count;
  - state → RUN.
- **cfg_load with cfg_len = 0 or > MAX_LEN:**
  - cfg_err = 1 for one cycle;
  - state → IDLE;
  - history, fill and match_count cleared.
- cfg_load is accepted in any state. Reloading in RUN restarts detection from empty.
- **History:** MAX_LEN-bit shift register. On an accepted bit, hist ← {hist[MAX_LEN-2:0], x}, so the newest bit is at hist[0].
- **Fill counter:** counts accepted bits since start or last restart, saturating at MAX_LEN.
- **Match condition** on an accepted bit in RUN: fill_next ≥ len AND hist_next[len-1:0] == pattern[len-1:0]. Bits above len are ignored.
- **On match:**
  - y ← 1;
  - match_count increments unless it is already all-ones.
  - Non-overlap mode only: fill ← 0, so bits of the matched occurrence cannot be reused.
- Overlap mode keeps fill, so a pattern suffix may start the next match.
- x_valid low: history, fill and counter hold; y ← 0.
- In IDLE, bits are ignored and y stays 0.

## Timing
- Reset values: y = 0, match_count = 0, cfg_err = 0, active = 0; history, fill and pattern = 0; state IDLE.
- Latency: y is high in the cycle after the edge that samples the last pattern bit. It is a registered output with no combinational path from x.
- Back-to-back matches are possible in overlap mode (periodic patterns such as 11) and give y high on consecutive cycles.
- cfg_load takes effect on its edge. active is high in the following cycle, and the first bit accepted is the one with x_valid on the next edge.
- cfg_load and x_valid in the same cycle: the load wins, the bit is discarded, and y = 0.
- reset and cfg_load in the same cycle: reset wins.
- Reset mid-stream aborts any partial match. No match is reported for bits straddling the reset.
- cfg_err and y are never high together.

## Structure
- Package prog_seqdet_pkg holds:
  - state enum (IDLE, RUN);
  - LEN_W helper function;
  - default MAX_LEN and COUNT_W constants.
- Sub-module seqdet_window holds the history shift register and fill counter. It has shift, restart and clear inputs and outputs hist_next and fill_next.
- The top level holds the config registers, FSM, comparator with length mask, and counter.

## Test plan
- **Overlap, 10101:** load pattern 10101, len 5, overlap 1; stream 1010101 → y pulses after bits 5 and 7; match_count = 2.
- **Non-overlap, same pattern:** overlap 0, same stream → y after bit 5 only; match_count = 1.
- **Full width, gapped input:** MAX_LEN = 8, pattern 11001011, len 8; x_valid toggled 0/1 between bits → single y one cycle after the 8th valid bit; idle cycles do not break the match.
- **Bad length and reload:**
  - load with cfg_len = 0 → cfg_err pulse, active = 0, no y on any stream;
  - then a legal load of len 2, pattern 11; stream 111 → y after bits 2 and 3.
- **Saturation and restart:**
  - COUNT_W = 2, pattern 1, len 1, stream of six 1s → match_count stops at 3 while y pulses six times;
  - cfg_load → count 0.
- **Mid-stream abort:**
  - stream 1010 then reset, then 1 → no y, state IDLE;
  - in RUN, assert cfg_load together with the 5th bit of 10101 → no y, bit discarded.

Source files
------------

// File: rtl/prog_sequence_detector_pkg.sv
// Shared types and sizing helpers for the programmable serial pattern detector.
package prog_seqdet_pkg;

   localparam int DEFAULT_MAX_LEN = 8;
   localparam int DEFAULT_COUNT_W = 16;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Width needed to hold a length value in the range 0..max_len.
   function automatic int len_width(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/prog_sequence_detector_window.sv
// Bit history shift register plus a saturating count of bits seen since the last restart.
module seqdet_window
   import prog_seqdet_pkg::*;
#(
   parameter int MAX_LEN = DEFAULT_MAX_LEN,
   parameter int FILL_W  = len_width(MAX_LEN)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               shift,
   input  logic               restart,
   input  logic               clear,
   input  logic               x,
   output logic [MAX_LEN-1:0] hist_next,
   output logic [FILL_W-1:0]  fill_next
);

   logic [MAX_LEN-1:0] hist_q, hist_d;
   logic [FILL_W-1:0]  fill_q, fill_d;

   // hist_next/fill_next describe the window as if the bit were taken, independent of
   // restart, so the caller can decide on a match without forming a combinational loop.
   always_comb begin
      hist_next = {hist_q[MAX_LEN-2:0], x};
      fill_next = (fill_q == FILL_W'(MAX_LEN)) ? fill_q : fill_q + FILL_W'(1);
      hist_d    = hist_q;
      fill_d    = fill_q;
      if (clear) begin
         hist_d = '0;
         fill_d = '0;
      end else if (shift) begin
         hist_d = hist_next;
         fill_d = restart ? '0 : fill_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hist_q <= '0;
         fill_q <= '0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
      end
   end

endmodule

// File: rtl/prog_sequence_detector.sv
// Runtime-programmable serial pattern detector with overlap control, valid qualifier
// and a saturating match counter.
module prog_sequence_detector
   import prog_seqdet_pkg::*;
#(
   parameter int MAX_LEN = DEFAULT_MAX_LEN,
   parameter int COUNT_W = DEFAULT_COUNT_W,
   parameter int LEN_W   = len_width(MAX_LEN)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               x_valid,
   input  logic               x,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   output logic               y,
   output logic [COUNT_W-1:0] match_count,
   output logic               cfg_err,
   output logic               active
);

   state_e             state_q, state_d;
   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               ovl_q, ovl_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               y_q, y_d;
   logic               err_q, err_d;

   logic               cfg_ok;
   logic               shift;
   logic               match;
   logic               restart;
   logic [MAX_LEN-1:0] len_mask;
   logic [MAX_LEN-1:0] hist_next;
   logic [LEN_W-1:0]   fill_next;

   seqdet_window #(
      .MAX_LEN (MAX_LEN),
      .FILL_W  (LEN_W)
   ) u_window (
      .clk       (clk),
      .reset     (reset),
      .shift     (shift),
      .restart   (restart),
      .clear     (cfg_load),
      .x         (x),
      .hist_next (hist_next),
      .fill_next (fill_next)
   );

   // A load in the same cycle as a valid bit discards the bit.
   always_comb begin
      cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
      shift  = (state_q == RUN) && x_valid && !cfg_load;
      for (int i = 0; i < MAX_LEN; i++) begin
         len_mask[i] = (LEN_W'(i) < len_q);
      end
      match   = shift && (fill_next >= len_q) && (((hist_next ^ pat_q) & len_mask) == '0);
      restart = match && !ovl_q;
   end

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      len_d   = len_q;
      ovl_d   = ovl_q;
      count_d = count_q;
      y_d     = match;
      err_d   = 1'b0;
      if (cfg_load) begin
         count_d = '0;
         if (cfg_ok) begin
            pat_d   = cfg_pattern;
            len_d   = cfg_len;
            ovl_d   = cfg_overlap;
            state_d = RUN;
         end else begin
            err_d   = 1'b1;
            state_d = IDLE;
         end
      end else if (match && !(&count_q)) begin
         count_d = count_q + COUNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pat_q   <= '0;
         len_q   <= '0;
         ovl_q   <= 1'b0;
         count_q <= '0;
         y_q     <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         ovl_q   <= ovl_d;
         count_q <= count_d;
         y_q     <= y_d;
         err_q   <= err_d;
      end
   end

   assign y           = y_q;
   assign match_count = count_q;
   assign cfg_err     = err_q;
   assign active      = (state_q == RUN);

endmodule
